// File: rtl/key_input_conditioner.sv
// Push-button debouncer and ASCII letter validator feeding the enigma core.
// Build option: define KIC_CASE_FOLD_EN to accept lower-case letters, folded to upper case.
module key_input_conditioner #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W           = 20
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       key_n,
   input  logic [7:0] sw_char,
   output logic [7:0] char_input,
   output logic       char_pressed,
   output logic       char_rejected,
   output logic       busy
);

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      DEB_PRESS   = 2'd1,
      HELD        = 2'd2,
      DEB_RELEASE = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             r_key_meta;
   logic             r_key_s;
   logic [7:0]       r_sw_meta;
   logic [7:0]       r_sw_s;
   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [7:0]       r_char;
   logic             r_pressed;
   logic             r_rejected;

   state_t           w_next_state;
   logic [CNT_W-1:0] w_cnt_next;
   logic             w_accept;
   logic             w_is_upper;
   logic             w_letter_ok;
   logic [7:0]       w_letter;

   // Two-flop synchronisers; the key idles released so reset never looks like a press.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_key_meta <= 1'b1;
         r_key_s    <= 1'b1;
         r_sw_meta  <= 8'h00;
         r_sw_s     <= 8'h00;
      end else begin
         r_key_meta <= key_n;
         r_key_s    <= r_key_meta;
         r_sw_meta  <= sw_char;
         r_sw_s     <= r_sw_meta;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next_state;
         r_cnt   <= w_cnt_next;
      end
   end

   // Counter stops at LP_LAST: reaching it either exits the debounce state or a bounce does.
   always_comb begin
      w_next_state = r_state;
      w_cnt_next   = r_cnt;
      case (r_state)
         IDLE: begin
            if (!r_key_s) begin
               w_next_state = DEB_PRESS;
               w_cnt_next   = '0;
            end
         end
         DEB_PRESS: begin
            if (r_key_s)
               w_next_state = IDLE;
            else if (r_cnt == LP_LAST)
               w_next_state = HELD;
            else
               w_cnt_next = r_cnt + 1'b1;
         end
         HELD: begin
            if (r_key_s) begin
               w_next_state = DEB_RELEASE;
               w_cnt_next   = '0;
            end
         end
         DEB_RELEASE: begin
            if (!r_key_s)
               w_next_state = HELD;
            else if (r_cnt == LP_LAST)
               w_next_state = IDLE;
            else
               w_cnt_next = r_cnt + 1'b1;
         end
         default: w_next_state = IDLE;
      endcase
   end

   always_comb begin
      busy       = (r_state != IDLE);
      w_accept   = (r_state == DEB_PRESS) && !r_key_s && (r_cnt == LP_LAST);
      w_is_upper = (r_sw_s >= 8'h41) && (r_sw_s <= 8'h5A);
   end

`ifdef KIC_CASE_FOLD_EN
   logic w_is_lower;
   always_comb begin
      w_is_lower  = (r_sw_s >= 8'h61) && (r_sw_s <= 8'h7A);
      w_letter_ok = w_is_upper || w_is_lower;
      w_letter    = w_is_lower ? (r_sw_s - 8'h20) : r_sw_s;
   end
`else
   always_comb begin
      w_letter_ok = w_is_upper;
      w_letter    = r_sw_s;
   end
`endif

   // Strobes and the held letter all launch from the same accept edge.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_char     <= 8'h41;
         r_pressed  <= 1'b0;
         r_rejected <= 1'b0;
      end else begin
         r_pressed  <= w_accept && w_letter_ok;
         r_rejected <= w_accept && !w_letter_ok;
         if (w_accept && w_letter_ok)
            r_char <= w_letter;
      end
   end

   assign char_input    = r_char;
   assign char_pressed  = r_pressed;
   assign char_rejected = r_rejected;

endmodule
